// File: rtl/axi4lite_regbank_for_pix28_fw.sv
// Register bank between the AXI4-Lite register interface and pix28 firmware logic.
// Write registers are level or self-clearing pulse; read registers are plain or sticky clear-on-read.
module axi4lite_regbank_for_pix28_fw #(
  parameter int unsigned      C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned      N_REG              = 4,
  parameter int unsigned      N_WR               = 2,
  parameter logic [N_WR-1:0]  WR_PULSE_EN        = '0,
  parameter logic [N_REG-1:0] RD_COR_EN          = '0
) (
  input  logic                                      S_AXI_ACLK,
  input  logic                                      S_AXI_ARESETN,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]             reg_wrdout,
  input  logic [N_REG*(C_S_AXI_DATA_WIDTH/8)-1:0]   reg_wrByteStrobe,
  input  logic [N_REG-1:0]                          reg_rdStrobe,
  output logic [N_REG*C_S_AXI_DATA_WIDTH-1:0]       reg_rddin,
  output logic [N_WR*C_S_AXI_DATA_WIDTH-1:0]        sw_write32,
  output logic [N_WR-1:0]                           sw_write_upd,
  input  logic [N_REG*C_S_AXI_DATA_WIDTH-1:0]       sw_read32,
  output logic [N_REG-1:0]                          sw_read_ack
);

  localparam int unsigned W  = C_S_AXI_DATA_WIDTH;
  localparam int unsigned NB = W / 8;

  if ((W % 8) != 0) begin : gen_err_width
    $error("C_S_AXI_DATA_WIDTH must be a multiple of 8");
  end
  if ((N_WR < 1) || (N_WR > N_REG)) begin : gen_err_nwr
    $error("N_WR must satisfy 1 <= N_WR <= N_REG");
  end

  // Strobes aimed at read-only indices are intentionally dropped.
  if (N_WR < N_REG) begin : gen_ro_strb
    logic unused_ro_strb;
    assign unused_ro_strb = ^reg_wrByteStrobe[N_REG*NB-1:N_WR*NB];
  end

  for (genvar i = 0; i < N_WR; i++) begin : gen_wr
    logic [NB-1:0] strb;
    logic [W-1:0]  wr_d, wr_q;
    logic          upd_q;

    assign strb = reg_wrByteStrobe[i*NB +: NB];

    always_comb begin
      // Pulse mode starts from zero each cycle, so unstrobed bytes read 0.
      wr_d = WR_PULSE_EN[i] ? '0 : wr_q;
      for (int b = 0; b < NB; b++) begin
        if (strb[b]) wr_d[b*8 +: 8] = reg_wrdout[b*8 +: 8];
      end
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
        wr_q  <= '0;
        upd_q <= 1'b0;
      end else begin
        wr_q  <= wr_d;
        upd_q <= |strb;
      end
    end

    assign sw_write32[i*W +: W] = wr_q;
    assign sw_write_upd[i]      = upd_q;
  end

  for (genvar i = 0; i < N_REG; i++) begin : gen_rd
    logic [W-1:0] rd_in, rd_src, rddin_q;
    logic         ack_q;

    assign rd_in = sw_read32[i*W +: W];

    if (RD_COR_EN[i]) begin : gen_cor
      logic [W-1:0] acc_q;
      // Bits arriving in the strobe cycle go straight out and are not kept in acc.
      assign rd_src = acc_q | rd_in;
      always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN)       acc_q <= '0;
        else if (reg_rdStrobe[i]) acc_q <= '0;
        else                      acc_q <= rd_src;
      end
    end else begin : gen_plain
      assign rd_src = rd_in;
    end

    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
      if (!S_AXI_ARESETN) begin
        rddin_q <= '0;
        ack_q   <= 1'b0;
      end else begin
        if (reg_rdStrobe[i]) rddin_q <= rd_src;
        ack_q <= reg_rdStrobe[i];
      end
    end

    assign reg_rddin[i*W +: W] = rddin_q;
    assign sw_read_ack[i]      = ack_q;
  end

endmodule
